// File: rtl/hd_to_mi_loader.sv
// hd_to_mi_loader: block-copy engine from the hard-disk model into instruction memory.
// One word per ISSUE -> WAIT (HD_LAT cycles) -> WRITE round trip; busy holds the
// processor off, and done pulses once per request (also for a zero-length request).
// Optional feature: define HD_CHECKSUM_EN to add the checksum_o running-sum port.
module hd_to_mi_loader #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MI_ADDR_W = 12,
    parameter int unsigned HD_ADDR_W = 16,
    parameter int unsigned HD_LAT    = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [HD_ADDR_W-1:0] hd_base_i,
    input  logic [MI_ADDR_W-1:0] mi_base_i,
    input  logic [MI_ADDR_W:0]   word_count_i,
    input  logic [DATA_W-1:0]    hd_rdata_i,
    output logic [HD_ADDR_W-1:0] hd_addr_o,
    output logic                 hd_rd_o,
    output logic [MI_ADDR_W-1:0] mi_addr_o,
    output logic [DATA_W-1:0]    mi_wdata_o,
    output logic                 mi_we_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef HD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]    checksum_o
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    // Index of the final WAIT cycle; HD_LAT is limited to 1..15 so it fits in 4 bits.
    localparam logic [3:0] WaitLast = 4'(HD_LAT - 1);

    state_e                 state_q;
    logic [HD_ADDR_W-1:0]   hd_ptr_q;
    logic [MI_ADDR_W-1:0]   mi_ptr_q;
    logic [MI_ADDR_W:0]     remain_q;
    logic [3:0]             wait_cnt_q;
    logic [HD_ADDR_W-1:0]   hd_addr_q;
    logic                   hd_rd_q;
    logic [MI_ADDR_W-1:0]   mi_addr_q;
    logic [DATA_W-1:0]      mi_wdata_q;
    logic                   mi_we_q;
    logic                   busy_q;
    logic                   done_q;

    // Copy FSM with all outputs registered alongside the state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            hd_ptr_q   <= '0;
            mi_ptr_q   <= '0;
            remain_q   <= '0;
            wait_cnt_q <= '0;
            hd_addr_q  <= '0;
            hd_rd_q    <= 1'b0;
            mi_addr_q  <= '0;
            mi_wdata_q <= '0;
            mi_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            hd_rd_q <= 1'b0;
            mi_we_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (word_count_i != '0) begin
                            hd_ptr_q  <= hd_base_i;
                            mi_ptr_q  <= mi_base_i;
                            remain_q  <= word_count_i;
                            hd_addr_q <= hd_base_i;
                            hd_rd_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= StIssue;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StIssue: begin
                    wait_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (wait_cnt_q == WaitLast) begin
                        mi_wdata_q <= hd_rdata_i;
                        mi_addr_q  <= mi_ptr_q;
                        mi_we_q    <= 1'b1;
                        state_q    <= StWrite;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StWrite: begin
                    hd_ptr_q <= hd_ptr_q + HD_ADDR_W'(1);
                    mi_ptr_q <= mi_ptr_q + MI_ADDR_W'(1);
                    remain_q <= remain_q - (MI_ADDR_W + 1)'(1);
                    if (remain_q == (MI_ADDR_W + 1)'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        hd_addr_q <= hd_ptr_q + HD_ADDR_W'(1);
                        hd_rd_q   <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef HD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running sum of written words; restarts whenever a request is accepted.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            checksum_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            checksum_q <= '0;
        end else if (state_q == StWrite) begin
            checksum_q <= checksum_q + mi_wdata_q;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign hd_addr_o  = hd_addr_q;
    assign hd_rd_o    = hd_rd_q;
    assign mi_addr_o  = mi_addr_q;
    assign mi_wdata_o = mi_wdata_q;
    assign mi_we_o    = mi_we_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
